nl_coupling_accumulator: RTL

Sequential stage directly downstream of the non-linear DAC. It consumes the DAC's 8-bit sign-magnitude cos/sin results, one per neighbour, and multiplies each by a signed coupling weight. It accumulates the weighted terms over one neighbour group and emits a saturated two's-complement coupling sum per group to the phase-update logic, using valid/ready handshakes on both sides.

---
 rtl/nl_coupling_accumulator_pkg.sv | 23 ++
 rtl/nl_coupling_accumulator_weight_mult.sv | 26 ++
 rtl/nl_coupling_accumulator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nl_coupling_accumulator_pkg.sv
// Shared types and constants for the non-linear DAC coupling accumulator.
package nl_coupling_accumulator_pkg;

    localparam int unsigned NL_WIDTH        = 8;
    localparam int unsigned NL_SIGN_BIT     = 7;
    localparam int unsigned NL_WEIGHT_WIDTH = 4;
    localparam int unsigned NL_ACC_WIDTH    = 16;

    // DAC result: sign-magnitude, bit 7 is the sign.
    typedef struct packed {
        logic                   sign;
        logic [NL_SIGN_BIT-1:0] mag;
    } NL_out_phase_t;

    typedef logic signed [NL_WEIGHT_WIDTH-1:0] nl_weight_t;
    typedef logic signed [NL_ACC_WIDTH-1:0]    nl_acc_t;

    typedef logic [1:0] nl_acc_state_t;
    localparam nl_acc_state_t ST_ACC   = 2'd0;
    localparam nl_acc_state_t ST_DRAIN = 2'd1;
    localparam nl_acc_state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/nl_coupling_accumulator_weight_mult.sv
// Sign-magnitude to two's-complement conversion followed by a signed weight multiply.
module nl_weight_mult
    import nl_coupling_accumulator_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  NL_out_phase_t                             nl_i,
    input  logic signed [WEIGHT_WIDTH-1:0]            weight_i,
    output logic signed [NL_WIDTH+WEIGHT_WIDTH-1:0]   product_c
);

    localparam int unsigned PROD_W = NL_WIDTH + WEIGHT_WIDTH;

    logic signed [PROD_W-1:0] mag_c;
    logic signed [PROD_W-1:0] val_c;
    logic signed [PROD_W-1:0] weight_c;

    // Negating a zero magnitude yields zero, so 8'h80 needs no special case.
    always_comb begin
        mag_c     = $signed({{(PROD_W-NL_SIGN_BIT){1'b0}}, nl_i.mag});
        val_c     = nl_i.sign ? -mag_c : mag_c;
        weight_c  = PROD_W'(weight_i);
        product_c = val_c * weight_c;
    end

endmodule

// File: rtl/nl_coupling_accumulator.sv
// Weighted, saturating accumulation of DAC results over one neighbour group,
// with valid/ready handshakes on input beats and on the per-group result.
module nl_coupling_accumulator
    import nl_coupling_accumulator_pkg::*;
#(
    parameter int unsigned MAX_NEIGHBORS = 16,
    parameter int unsigned WEIGHT_WIDTH  = 4,
    parameter int unsigned ACC_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [7:0]                            in_nl,
    input  logic [WEIGHT_WIDTH-1:0]               in_weight,
    input  logic                                  in_mode,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACC_WIDTH-1:0]                  out_sum,
    output logic [$clog2(MAX_NEIGHBORS+1)-1:0]    out_count,
    output logic                                  out_mode,
    output logic                                  out_sat
);

    localparam int unsigned CNT_W  = $clog2(MAX_NEIGHBORS + 1);
    localparam int unsigned PROD_W = NL_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NEIGHBORS);
    localparam logic signed [SUM_W-1:0] SUM_MAX =
        $signed({{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    nl_acc_state_t               state_q, state_d;
    logic                        in_ready_q, in_ready_d;
    logic                        first_q, first_d;
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_last_q, s1_last_d;
    logic                        s1_first_q, s1_first_d;
    logic signed [PROD_W-1:0]    s1_prod_q, s1_prod_d;
    logic                        mode_q, mode_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        sat_q, sat_d;
    logic                        out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]        out_sum_q, out_sum_d;
    logic [CNT_W-1:0]            out_count_q, out_count_d;
    logic                        out_mode_q, out_mode_d;
    logic                        out_sat_q, out_sat_d;

    logic                        accept_c;
    logic signed [PROD_W-1:0]    prod_c;
    logic signed [SUM_W-1:0]     base_c;
    logic signed [SUM_W-1:0]     sum_c;
    logic signed [ACC_WIDTH-1:0] clamp_c;
    logic                        clip_c;

    assign accept_c = in_valid && in_ready_q;

    nl_weight_mult #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_weight_mult (
        .nl_i      (in_nl),
        .weight_i  ($signed(in_weight)),
        .product_c (prod_c)
    );

    // Stage-2 add with clamp; a group's first term starts from zero.
    always_comb begin
        base_c  = s1_first_q ? '0 : SUM_W'(acc_q);
        sum_c   = base_c + SUM_W'(s1_prod_q);
        clip_c  = 1'b0;
        clamp_c = sum_c[ACC_WIDTH-1:0];
        if (sum_c > SUM_MAX) begin
            clamp_c = SUM_MAX[ACC_WIDTH-1:0];
            clip_c  = 1'b1;
        end else if (sum_c < SUM_MIN) begin
            clamp_c = SUM_MIN[ACC_WIDTH-1:0];
            clip_c  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        s1_valid_d  = accept_c;
        s1_last_d   = accept_c && in_last;
        s1_first_d  = s1_first_q;
        s1_prod_d   = s1_prod_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_mode_d  = out_mode_q;
        out_sat_d   = out_sat_q;

        if (accept_c) begin
            s1_prod_d  = prod_c;
            s1_first_d = first_q;
            first_d    = 1'b0;
            if (first_q) begin
                mode_d = in_mode;
            end
        end

        if (s1_valid_q) begin
            acc_d = clamp_c;
            if (s1_first_q) begin
                count_d = CNT_W'(1);
                sat_d   = clip_c;
            end else if (count_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
                sat_d   = sat_q | clip_c;
            end
        end

        case (state_q)
            ST_ACC: begin
                if (accept_c && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            // Publish only once the last product has been folded into acc_q.
            ST_DRAIN: begin
                if (!(s1_valid_q && s1_last_q)) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_q;
                    out_count_d = count_q;
                    out_mode_d  = mode_q;
                    out_sat_d   = sat_q;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    sat_d       = 1'b0;
                    first_d     = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase

        in_ready_d = (state_d == ST_ACC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            in_ready_q  <= 1'b1;
            first_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_prod_q   <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_mode_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            first_q     <= first_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_first_q  <= s1_first_d;
            s1_prod_q   <= s1_prod_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_mode_q  <= out_mode_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_mode  = out_mode_q;
    assign out_sat   = out_sat_q;

endmodule
